// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the byte-serial
// memory controller.
package mem_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    // Address bits [17:16] of the memory-mapped UART window
    localparam logic [1:0] IO_ADDR_MATCH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic [2:0] byte_count(input logic [2:0] size);
        case (size)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Client, IO and RAM signals of the memory controller; master is the
// client/RAM side, slave is the controller.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                  in_rollback;
    logic                  in_ls_ena;
    logic                  in_ls_iswrite;
    logic [DATA_WIDTH-1:0] in_ls_addr;
    logic [DATA_WIDTH-1:0] in_ls_data;
    logic [2:0]            in_ls_size;
    logic                  out_ls_ready;
    logic [DATA_WIDTH-1:0] out_ls_data;
    logic                  in_if_ena;
    logic [DATA_WIDTH-1:0] in_if_addr;
    logic                  out_if_ready;
    logic [DATA_WIDTH-1:0] out_if_inst;
    logic                  in_io_buffer_full;
    logic [7:0]            in_ram_data;
    logic [DATA_WIDTH-1:0] out_ram_addr;
    logic [7:0]            out_ram_data;
    logic                  out_ram_wr;

    modport master (
        output in_rollback, in_ls_ena, in_ls_iswrite, in_ls_addr,
        output in_ls_data, in_ls_size, in_if_ena, in_if_addr,
        output in_io_buffer_full, in_ram_data,
        input  out_ls_ready, out_ls_data, out_if_ready, out_if_inst,
        input  out_ram_addr, out_ram_data, out_ram_wr
    );

    modport slave (
        input  in_rollback, in_ls_ena, in_ls_iswrite, in_ls_addr,
        input  in_ls_data, in_ls_size, in_if_ena, in_if_addr,
        input  in_io_buffer_full, in_ram_data,
        output out_ls_ready, out_ls_data, out_if_ready, out_if_inst,
        output out_ram_addr, out_ram_data, out_ram_wr
    );

endinterface

// File: rtl/mem_req_slot.sv
// Per-client pending request latch; presents a same-cycle pulse directly
// so an idle controller can start on it without an extra cycle.
module mem_req_slot
    import mem_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set,
    input  logic                  set_wr,
    input  logic [DATA_WIDTH-1:0] set_addr,
    input  logic [DATA_WIDTH-1:0] set_data,
    input  logic [2:0]            set_size,
    input  logic                  take,
    input  logic                  rollback,
    output logic                  valid,
    output logic                  iswrite,
    output logic [DATA_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [2:0]            size
);

    logic                  pend_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [2:0]            size_q;
    logic                  set_ok;
    logic                  keep;

    // Rollback drops reads only; stores always survive
    assign set_ok  = set && !(rollback && !set_wr);
    assign keep    = pend_q && !(rollback && !wr_q);
    assign valid   = set_ok || keep;
    assign iswrite = set_ok ? set_wr   : wr_q;
    assign addr    = set_ok ? set_addr : addr_q;
    assign data    = set_ok ? set_data : data_q;
    assign size    = set_ok ? set_size : size_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= FALSE;
            wr_q   <= FALSE;
            addr_q <= ZERO_DATA;
            data_q <= ZERO_DATA;
            size_q <= 3'd0;
        end else begin
            pend_q <= valid && !take;
            if (set_ok) begin
                wr_q   <= set_wr;
                addr_q <= set_addr;
                data_q <= set_data;
                size_q <= set_size;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and LSQ requests onto an 8-bit synchronous RAM,
// splitting accesses into byte transfers and reassembling reads.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);

    state_t                state_q, state_d;
    logic [2:0]            k_q, n_q, kb;
    logic [DATA_WIDTH-1:0] base_q, wdata_q, result_q, merged;
    logic                  owner_ls_q;
    logic                  ls_ready_q, if_ready_q;
    logic [DATA_WIDTH-1:0] ls_data_q, if_inst_q;

    logic                  ls_valid, ls_wr, if_valid, if_wr;
    logic [DATA_WIDTH-1:0] ls_addr, ls_data, if_addr, if_data;
    logic [2:0]            ls_size, if_size;
    logic                  take_ls, take_if, done, ls_stall;
    logic [DATA_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_data;
    logic                  ram_wr;

    mem_req_slot u_ls_slot (
        .clk(clk), .rst(rst),
        .set(bus.in_ls_ena), .set_wr(bus.in_ls_iswrite),
        .set_addr(bus.in_ls_addr), .set_data(bus.in_ls_data),
        .set_size(bus.in_ls_size),
        .take(take_ls), .rollback(bus.in_rollback),
        .valid(ls_valid), .iswrite(ls_wr), .addr(ls_addr),
        .data(ls_data), .size(ls_size)
    );

    mem_req_slot u_if_slot (
        .clk(clk), .rst(rst),
        .set(bus.in_if_ena), .set_wr(FALSE),
        .set_addr(bus.in_if_addr), .set_data(ZERO_DATA),
        .set_size(3'd4),
        .take(take_if), .rollback(bus.in_rollback),
        .valid(if_valid), .iswrite(if_wr), .addr(if_addr),
        .data(if_data), .size(if_size)
    );

    assign ls_stall = ls_valid && ls_wr && bus.in_io_buffer_full
                   && (ls_addr[17:16] == IO_ADDR_MATCH);

    // k_q lags one byte behind in READ; kb is the byte being captured
    assign kb     = k_q - 3'd1;
    assign merged = result_q
                  | (DATA_WIDTH'(bus.in_ram_data) << {kb[1:0], 3'b000});

    always_comb begin
        state_d  = state_q;
        take_ls  = FALSE;
        take_if  = FALSE;
        done     = FALSE;
        ram_addr = ZERO_DATA;
        ram_data = 8'd0;
        ram_wr   = FALSE;
        unique case (state_q)
            ST_IDLE: begin
                if (ls_valid) begin
                    if (!ls_stall) begin
                        take_ls = TRUE;
                        state_d = ls_wr ? ST_WRITE : ST_READ;
                    end
                end else if (if_valid) begin
                    take_if = TRUE;
                    state_d = if_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (k_q < n_q)
                    ram_addr = base_q + DATA_WIDTH'(k_q);
                if (bus.in_rollback) begin
                    state_d = ST_IDLE;
                end else if (k_q == n_q) begin
                    done    = TRUE;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                ram_addr = base_q + DATA_WIDTH'(k_q);
                ram_data = 8'(wdata_q >> {k_q[1:0], 3'b000});
                ram_wr   = TRUE;
                if (k_q == n_q - 3'd1) begin
                    done    = TRUE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q        <= 3'd0;
            n_q        <= 3'd0;
            base_q     <= ZERO_DATA;
            wdata_q    <= ZERO_DATA;
            result_q   <= ZERO_DATA;
            owner_ls_q <= FALSE;
            ls_ready_q <= FALSE;
            if_ready_q <= FALSE;
            ls_data_q  <= ZERO_DATA;
            if_inst_q  <= ZERO_DATA;
        end else begin
            ls_ready_q <= FALSE;
            if_ready_q <= FALSE;
            ls_data_q  <= ZERO_DATA;
            if_inst_q  <= ZERO_DATA;
            if (take_ls || take_if) begin
                base_q     <= take_ls ? ls_addr : if_addr;
                wdata_q    <= take_ls ? ls_data : if_data;
                n_q        <= byte_count(take_ls ? ls_size : if_size);
                owner_ls_q <= take_ls;
                k_q        <= 3'd0;
                result_q   <= ZERO_DATA;
            end else if (state_q == ST_READ) begin
                k_q <= k_q + 3'd1;
                if (k_q != 3'd0) result_q <= merged;
                if (done) begin
                    ls_ready_q <= owner_ls_q;
                    if_ready_q <= !owner_ls_q;
                    if (owner_ls_q) ls_data_q <= merged;
                    else            if_inst_q <= merged;
                end
            end else if (state_q == ST_WRITE) begin
                k_q <= k_q + 3'd1;
                if (done) ls_ready_q <= TRUE;
            end
        end
    end

    assign bus.out_ram_addr = ram_addr;
    assign bus.out_ram_data = ram_data;
    assign bus.out_ram_wr   = ram_wr;
    assign bus.out_ls_ready = ls_ready_q;
    assign bus.out_ls_data  = ls_data_q;
    assign bus.out_if_ready = if_ready_q;
    assign bus.out_if_inst  = if_inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected RAM
// traffic and ready pulses; a negedge monitor pops and compares.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    typedef struct {
        logic        ls;
        logic [31:0] data;
        int          cyc;
    } rdy_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   t0;

    rdy_t rq[$];
    acc_t wq[$];
    acc_t aq[$];
    rdy_t mr;
    acc_t ma;

    logic [7:0] mem [0:1023];

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: returns the byte addressed last cycle
    always @(posedge clk) bus.in_ram_data <= mem[bus.out_ram_addr[9:0]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s actual=%h required=none at cycle %0d",
                 name, act, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_ram_wr) begin
                if (wq.size() == 0) begin
                    unexp("wr_unexpected", bus.out_ram_addr);
                end else begin
                    ma = wq.pop_front();
                    chk("wr_addr", bus.out_ram_addr, ma.addr);
                    chk("wr_data", {24'd0, bus.out_ram_data}, {24'd0, ma.data});
                    chk("wr_cycle", 32'(cyc), 32'(ma.cyc));
                end
            end else if (bus.out_ram_addr != 32'd0) begin
                if (aq.size() == 0) begin
                    unexp("rd_addr_unexpected", bus.out_ram_addr);
                end else begin
                    ma = aq.pop_front();
                    chk("rd_addr", bus.out_ram_addr, ma.addr);
                    chk("rd_cycle", 32'(cyc), 32'(ma.cyc));
                end
            end
            if (bus.out_ls_ready || bus.out_if_ready) begin
                if (rq.size() == 0) begin
                    unexp("ready_unexpected",
                          {30'd0, bus.out_ls_ready, bus.out_if_ready});
                end else begin
                    mr = rq.pop_front();
                    chk("ready_owner",
                        {30'd0, bus.out_ls_ready, bus.out_if_ready},
                        {30'd0, mr.ls, !mr.ls});
                    chk("ready_data",
                        mr.ls ? bus.out_ls_data : bus.out_if_inst, mr.data);
                    chk("ready_cycle", 32'(cyc), 32'(mr.cyc));
                end
            end else begin
                chk("idle_ls_data", bus.out_ls_data, 32'd0);
                chk("idle_if_inst", bus.out_if_inst, 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [31:0] addr, input int c);
        acc_t e;
        e.addr = addr;
        e.data = 8'd0;
        e.cyc  = c;
        aq.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [7:0] d,
                           input int c);
        acc_t e;
        e.addr = addr;
        e.data = d;
        e.cyc  = c;
        wq.push_back(e);
    endtask

    task automatic push_rdy(input logic ls, input logic [31:0] d,
                            input int c);
        rdy_t e;
        e.ls   = ls;
        e.data = d;
        e.cyc  = c;
        rq.push_back(e);
    endtask

    task automatic set_ls(input logic wr, input logic [31:0] addr,
                          input logic [31:0] d, input logic [2:0] size);
        bus.in_ls_iswrite = wr;
        bus.in_ls_addr    = addr;
        bus.in_ls_data    = d;
        bus.in_ls_size    = size;
        bus.in_ls_ena     = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rq.size() + wq.size() + aq.size() == 0) break;
            step(1);
        end
        if (rq.size() + wq.size() + aq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0",
                     rq.size() + wq.size() + aq.size());
            rq.delete();
            wq.delete();
            aq.delete();
        end
        step(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[4]    = 8'h13;
        mem[5]    = 8'h05;
        mem[6]    = 8'h00;
        mem[7]    = 8'h00;
        mem[8]    = 8'hAA;
        mem[9]    = 8'hBB;
        mem[10]   = 8'hCC;
        mem[11]   = 8'hDD;
        mem[16]   = 8'h34;
        mem[17]   = 8'h12;
        mem[32]   = 8'h80;
        mem[64]   = 8'h55;

        bus.in_rollback       = 1'b0;
        bus.in_ls_ena         = 1'b0;
        bus.in_ls_iswrite     = 1'b0;
        bus.in_ls_addr        = 32'd0;
        bus.in_ls_data        = 32'd0;
        bus.in_ls_size        = 3'd0;
        bus.in_if_ena         = 1'b0;
        bus.in_if_addr        = 32'd0;
        bus.in_io_buffer_full = 1'b0;

        step(2);
        chk("rst_ram_addr", bus.out_ram_addr, 32'd0);
        chk("rst_ram_wr", {31'd0, bus.out_ram_wr}, 32'd0);
        chk("rst_ram_data", {24'd0, bus.out_ram_data}, 32'd0);
        chk("rst_ls_ready", {31'd0, bus.out_ls_ready}, 32'd0);
        chk("rst_if_ready", {31'd0, bus.out_if_ready}, 32'd0);
        rst = 1'b0;
        step(2);

        // Word fetch from 0x4
        t0 = cyc;
        for (int k = 0; k < 4; k++) push_rd(32'h4 + 32'(k), t0 + 1 + k);
        push_rdy(1'b0, 32'h0000_0513, t0 + 6);
        bus.in_if_addr = 32'h4;
        bus.in_if_ena  = 1'b1;
        step(1);
        bus.in_if_ena  = 1'b0;
        drain(30);

        // Halfword store
        t0 = cyc;
        push_wr(32'h100, 8'hEF, t0 + 1);
        push_wr(32'h101, 8'hBE, t0 + 2);
        push_rdy(1'b1, 32'd0, t0 + 3);
        set_ls(1'b1, 32'h100, 32'hDEAD_BEEF, 3'd2);
        step(1);
        bus.in_ls_ena = 1'b0;
        drain(30);

        // Simultaneous fetch and byte load: LSQ first
        t0 = cyc;
        push_rd(32'h20, t0 + 1);
        push_rdy(1'b1, 32'h0000_0080, t0 + 3);
        for (int k = 0; k < 4; k++) push_rd(32'h4 + 32'(k), t0 + 4 + k);
        push_rdy(1'b0, 32'h0000_0513, t0 + 9);
        set_ls(1'b0, 32'h20, 32'hFFFF_FFFF, 3'd1);
        bus.in_if_addr = 32'h4;
        bus.in_if_ena  = 1'b1;
        step(1);
        bus.in_ls_ena  = 1'b0;
        bus.in_if_ena  = 1'b0;
        drain(40);

        // Size 3 is treated as a word
        t0 = cyc;
        for (int k = 0; k < 4; k++) push_rd(32'h8 + 32'(k), t0 + 1 + k);
        push_rdy(1'b1, 32'hDDCC_BBAA, t0 + 6);
        set_ls(1'b0, 32'h8, 32'd0, 3'd3);
        step(1);
        bus.in_ls_ena = 1'b0;
        drain(30);

        // Rollback in cycle 3 of a word fetch
        t0 = cyc;
        for (int k = 0; k < 3; k++) push_rd(32'h40 + 32'(k), t0 + 1 + k);
        bus.in_if_addr = 32'h40;
        bus.in_if_ena  = 1'b1;
        step(1);
        bus.in_if_ena  = 1'b0;
        step(2);
        bus.in_rollback = 1'b1;
        step(1);
        bus.in_rollback = 1'b0;
        drain(20);
        step(5);

        // Load after the aborted fetch
        t0 = cyc;
        push_rd(32'h10, t0 + 1);
        push_rd(32'h11, t0 + 2);
        push_rdy(1'b1, 32'h0000_1234, t0 + 4);
        set_ls(1'b0, 32'h10, 32'd0, 3'd2);
        step(1);
        bus.in_ls_ena = 1'b0;
        drain(30);

        // Store pulsed together with rollback is kept
        t0 = cyc;
        push_wr(32'h300, 8'h77, t0 + 1);
        push_rdy(1'b1, 32'd0, t0 + 2);
        set_ls(1'b1, 32'h300, 32'h0000_0077, 3'd1);
        bus.in_rollback = 1'b1;
        step(1);
        bus.in_ls_ena   = 1'b0;
        bus.in_rollback = 1'b0;
        drain(30);

        // IO store stalls while the UART buffer is full
        t0 = cyc;
        push_wr(32'h30000, 8'h5A, t0 + 6);
        push_rdy(1'b1, 32'd0, t0 + 7);
        bus.in_io_buffer_full = 1'b1;
        set_ls(1'b1, 32'h30000, 32'h1234_565A, 3'd1);
        step(1);
        bus.in_ls_ena = 1'b0;
        step(4);
        bus.in_io_buffer_full = 1'b0;
        drain(30);

        // Reset mid-write with a fetch pending
        t0 = cyc;
        push_wr(32'h200, 8'h44, t0 + 1);
        push_wr(32'h201, 8'h33, t0 + 2);
        set_ls(1'b1, 32'h200, 32'h1122_3344, 3'd4);
        step(1);
        bus.in_ls_ena  = 1'b0;
        bus.in_if_addr = 32'h4;
        bus.in_if_ena  = 1'b1;
        step(1);
        bus.in_if_ena  = 1'b0;
        #6;
        rst = 1'b1;
        #1;
        chk("arst_ram_addr", bus.out_ram_addr, 32'd0);
        chk("arst_ram_wr", {31'd0, bus.out_ram_wr}, 32'd0);
        chk("arst_ram_data", {24'd0, bus.out_ram_data}, 32'd0);
        chk("arst_ls_ready", {31'd0, bus.out_ls_ready}, 32'd0);
        chk("arst_if_ready", {31'd0, bus.out_if_ready}, 32'd0);
        step(2);
        rst = 1'b0;
        drain(10);
        step(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
